// File: rtl/idu_decode_queue_pkg.sv
// Shared decode constants for the IDU: opcodes, alu_op codes, instruction classes
// and the opcode-to-class mapping used by the decoder.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [5:0] ALU_ADDI    = 6'b000000;
  localparam logic [5:0] ALU_LUI     = 6'b000001;
  localparam logic [5:0] ALU_AUIPC   = 6'b000010;
  localparam logic [5:0] ALU_JAL     = 6'b000011;
  localparam logic [5:0] ALU_JALR    = 6'b000100;
  localparam logic [5:0] ALU_BEQ     = 6'b000110;
  localparam logic [5:0] ALU_LW      = 6'b001000;
  localparam logic [5:0] ALU_SW      = 6'b001001;
  localparam logic [5:0] ALU_EBREAK  = 6'b001011;
  localparam logic [5:0] ALU_UNKNOWN = 6'b001111;
  localparam logic [5:0] ALU_CSRRW   = 6'b110000;
  localparam logic [5:0] ALU_CSRRS   = 6'b110001;
  localparam logic [5:0] ALU_ECALL   = 6'b110010;
  localparam logic [5:0] ALU_MRET    = 6'b110011;
  localparam logic [5:0] ALU_NONE    = 6'b111111;

  typedef enum logic [2:0] {
    CLS_COMPUTE = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_SYSTEM  = 3'd5,
    CLS_OTHER   = 3'd6
  } inst_class_e;

  function automatic inst_class_e class_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC: class_of = CLS_COMPUTE;
      OPC_LOAD:                               class_of = CLS_LOAD;
      OPC_STORE:                              class_of = CLS_STORE;
      OPC_BRANCH:                             class_of = CLS_BRANCH;
      OPC_JAL, OPC_JALR:                      class_of = CLS_JUMP;
      OPC_SYSTEM:                             class_of = CLS_SYSTEM;
      default:                                class_of = CLS_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/idu_decode_queue_if.sv
// IFU->IDU->EXU handshake bundle: fetch side, flush, and the decoded head entry.
interface idu_decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [5:0]  out_alu_op;
  logic [2:0]  out_class;
  logic [11:0] out_csr_addr;
  logic        out_csr_wen;
  logic        out_is_ecall;
  logic        out_is_mret;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_class,
           out_csr_addr, out_csr_wen, out_is_ecall, out_is_mret
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_opcode, out_func3, out_func7,
           out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_class,
           out_csr_addr, out_csr_wen, out_is_ecall, out_is_mret
  );
endinterface

// File: rtl/idu_decode_queue_decoder.sv
// Pure combinational RV32I decoder for the queue head. With valid low every
// field reads 0 except alu_op, which reads all-ones.
module idu_decoder
  import idu_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [5:0]  alu_op,
  output logic [2:0]  cls,
  output logic [11:0] csr_addr,
  output logic        csr_wen,
  output logic        is_ecall,
  output logic        is_mret
);

  always_comb begin
    opcode   = '0;
    func3    = '0;
    func7    = '0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    imm      = '0;
    alu_op   = ALU_NONE;
    cls      = '0;
    csr_addr = '0;
    csr_wen  = 1'b0;
    is_ecall = 1'b0;
    is_mret  = 1'b0;
    if (valid) begin
      opcode = inst[6:0];
      func3  = inst[14:12];
      func7  = inst[31:25];
      rs1    = inst[19:15];
      rs2    = inst[24:20];
      rd     = inst[11:7];
      cls    = class_of(inst[6:0]);

      case (inst[6:0])
        OPC_LUI, OPC_AUIPC: imm = {inst[31:12], 12'b0};
        OPC_JAL:    imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        OPC_BRANCH: imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        OPC_STORE:  imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = {{21{inst[31]}}, inst[30:20]};
        default:    imm = '0;
      endcase

      alu_op = ALU_UNKNOWN;
      case (inst[6:0])
        OPC_OP_IMM: if (inst[14:12] == 3'b000) alu_op = ALU_ADDI;
        OPC_LUI:    alu_op = ALU_LUI;
        OPC_AUIPC:  alu_op = ALU_AUIPC;
        OPC_JAL:    alu_op = ALU_JAL;
        OPC_JALR:   alu_op = ALU_JALR;
        OPC_BRANCH: if (inst[14:12] == 3'b000) alu_op = ALU_BEQ;
        OPC_LOAD:   if (inst[14:12] == 3'b010) alu_op = ALU_LW;
        OPC_STORE:  if (inst[14:12] == 3'b010) alu_op = ALU_SW;
        OPC_SYSTEM: begin
          // ecall reads a7 (x17) for the service number
          if (inst == INST_ECALL) begin
            alu_op   = ALU_ECALL;
            is_ecall = 1'b1;
            rs1      = 5'd17;
          end else if (inst == INST_EBREAK) begin
            alu_op = ALU_EBREAK;
          end else if (inst == INST_MRET) begin
            alu_op  = ALU_MRET;
            is_mret = 1'b1;
          end else if (inst[14:12] == 3'b001 || inst[14:12] == 3'b010) begin
            alu_op   = inst[12] ? ALU_CSRRW : ALU_CSRRS;
            csr_wen  = 1'b1;
            csr_addr = inst[31:20];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/idu_decode_queue.sv
// Instruction queue between IFU and EXU with head decode and flush.
// Optional per-class retirement counters when IDU_PERF_EN is defined.
module idu_decode_queue
  import idu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  idu_decode_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0] level
`ifdef IDU_PERF_EN
  ,
  input  logic [2:0]             perf_sel,
  output logic [CNT_W-1:0]       perf_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          push;
  logic          pop;

  assign bus.in_ready  = (level != FULL_LEVEL);
  assign bus.out_valid = (level != '0);
  // flush wins over both handshakes in the same cycle
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  // payload needs no reset: it is only observed through a nonzero level
  always_ff @(posedge clock) begin
    if (push) begin
      inst_q[wr_ptr] <= bus.in_inst;
      pc_q[wr_ptr]   <= bus.in_pc;
    end
  end

  assign bus.out_inst = bus.out_valid ? inst_q[rd_ptr] : '0;
  assign bus.out_pc   = bus.out_valid ? pc_q[rd_ptr]   : '0;

  idu_decoder u_decoder (
    .valid    (bus.out_valid),
    .inst     (bus.out_inst),
    .opcode   (bus.out_opcode),
    .func3    (bus.out_func3),
    .func7    (bus.out_func7),
    .rs1      (bus.out_rs1),
    .rs2      (bus.out_rs2),
    .rd       (bus.out_rd),
    .imm      (bus.out_imm),
    .alu_op   (bus.out_alu_op),
    .cls      (bus.out_class),
    .csr_addr (bus.out_csr_addr),
    .csr_wen  (bus.out_csr_wen),
    .is_ecall (bus.out_is_ecall),
    .is_mret  (bus.out_is_mret)
  );

`ifdef IDU_PERF_EN
  // slots 0..6 count retirements per class, slot 7 counts all retirements
  logic [CNT_W-1:0] cnt_q [8];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else if (pop) begin
      cnt_q[bus.out_class] <= cnt_q[bus.out_class] + 1'b1;
      cnt_q[7]             <= cnt_q[7] + 1'b1;
    end
  end

  assign perf_cnt = cnt_q[perf_sel];
`endif

endmodule

// File: tb/tb_idu_decode_queue.sv
// Scoreboard bench for idu_decode_queue: directed test-plan cases, then random
// traffic with flushes and mid-run resets. Perf checks compile in with IDU_PERF_EN.
module tb_idu_decode_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  alu_op;
    logic [2:0]  cls;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic        ecall;
    logic        mret;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [$clog2(DEPTH):0] level;
`ifdef IDU_PERF_EN
  logic [2:0]       perf_sel;
  logic [CNT_W-1:0] perf_cnt;
  logic [CNT_W-1:0] pm [8];
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  idu_decode_queue_if bus();

  idu_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .level (level)
`ifdef IDU_PERF_EN
    ,
    .perf_sel (perf_sel),
    .perf_cnt (perf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_entry(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (inst %h/%h alu %b/%b imm %h/%h cls %0d/%0d) t=%0t",
               name, act, exp, act.inst, exp.inst, act.alu_op, exp.alu_op,
               act.imm, exp.imm, act.cls, exp.cls, $time);
    end
  endtask

  // Reference decode from the ISA rules: pick the mnemonic, then look up its code.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
    exp_t  e;
    string mn;
    int    v;
    e = '0;
    mn = "?";
    v = 0;
    e.pc = pc;
    e.inst = inst;
    e.opcode = inst[6:0];
    e.func3 = inst[14:12];
    e.func7 = inst[31:25];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd = inst[11:7];
    case (inst[6:0])
      7'h13: begin e.cls = 0; v = $signed(inst[31:20]); if (inst[14:12] == 0) mn = "addi"; end
      7'h33: e.cls = 0;
      7'h37: begin e.cls = 0; v = int'({inst[31:12], 12'h000}); mn = "lui"; end
      7'h17: begin e.cls = 0; v = int'({inst[31:12], 12'h000}); mn = "auipc"; end
      7'h6f: begin e.cls = 4; v = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}); mn = "jal"; end
      7'h67: begin e.cls = 4; v = $signed(inst[31:20]); mn = "jalr"; end
      7'h63: begin e.cls = 3; v = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); if (inst[14:12] == 0) mn = "beq"; end
      7'h03: begin e.cls = 1; v = $signed(inst[31:20]); if (inst[14:12] == 2) mn = "lw"; end
      7'h23: begin e.cls = 2; v = $signed({inst[31:25], inst[11:7]}); if (inst[14:12] == 2) mn = "sw"; end
      7'h73: begin
        e.cls = 5;
        if (inst == 32'h0000_0073) mn = "ecall";
        else if (inst == 32'h0010_0073) mn = "ebreak";
        else if (inst == 32'h3020_0073) mn = "mret";
        else if (inst[14:12] == 1) mn = "csrrw";
        else if (inst[14:12] == 2) mn = "csrrs";
      end
      default: e.cls = 6;
    endcase
    e.imm = v;
    case (mn)
      "addi":   e.alu_op = 6'd0;
      "lui":    e.alu_op = 6'd1;
      "auipc":  e.alu_op = 6'd2;
      "jal":    e.alu_op = 6'd3;
      "jalr":   e.alu_op = 6'd4;
      "beq":    e.alu_op = 6'd6;
      "lw":     e.alu_op = 6'd8;
      "sw":     e.alu_op = 6'd9;
      "ebreak": e.alu_op = 6'd11;
      "csrrw":  e.alu_op = 6'd48;
      "csrrs":  e.alu_op = 6'd49;
      "ecall":  e.alu_op = 6'd50;
      "mret":   e.alu_op = 6'd51;
      default:  e.alu_op = 6'd15;
    endcase
    if (mn == "ecall") begin e.ecall = 1'b1; e.rs1 = 5'd17; end
    if (mn == "mret") e.mret = 1'b1;
    if (mn == "csrrw" || mn == "csrrs") begin e.csr_wen = 1'b1; e.csr_addr = inst[31:20]; end
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t a;
    a.pc = bus.out_pc;
    a.inst = bus.out_inst;
    a.opcode = bus.out_opcode;
    a.func3 = bus.out_func3;
    a.func7 = bus.out_func7;
    a.rs1 = bus.out_rs1;
    a.rs2 = bus.out_rs2;
    a.rd = bus.out_rd;
    a.imm = bus.out_imm;
    a.alu_op = bus.out_alu_op;
    a.cls = bus.out_class;
    a.csr_addr = bus.out_csr_addr;
    a.csr_wen = bus.out_csr_wen;
    a.ecall = bus.out_is_ecall;
    a.mret = bus.out_is_mret;
    return a;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  begin r[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000; end
      1:  r[6:0] = 7'h33;
      2:  r[6:0] = 7'h37;
      3:  r[6:0] = 7'h17;
      4:  r[6:0] = 7'h6f;
      5:  r[6:0] = 7'h67;
      6:  begin r[6:0] = 7'h63; if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000; end
      7:  begin r[6:0] = 7'h03; if ($urandom_range(0, 1) == 1) r[14:12] = 3'b010; end
      8:  begin r[6:0] = 7'h23; if ($urandom_range(0, 1) == 1) r[14:12] = 3'b010; end
      9:  begin r[6:0] = 7'h73; r[14:12] = 3'($urandom_range(1, 2)); end
      10: case ($urandom_range(0, 2))
            0:       r = 32'h0000_0073;
            1:       r = 32'h0010_0073;
            default: r = 32'h3020_0073;
          endcase
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: checks status against the model, compares each retired head,
  // then applies this cycle's push/pop/flush to the model.
  always @(negedge clock) begin : monitor
    int   n;
    exp_t e;
    exp_t a;
    if (!reset) begin
      chk("reset_level", 32'(level), 0);
      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_in_ready", 32'(bus.in_ready), 1);
      sb.delete();
`ifdef IDU_PERF_EN
      for (int i = 0; i < 8; i++) pm[i] = '0;
`endif
    end else begin
      n = sb.size();
      chk("level", 32'(level), n);
      chk("in_ready", 32'(bus.in_ready), 32'(n != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
      a = dut_out();
      if (n == 0) begin
        e = '0;
        e.alu_op = 6'b111111;
        chk_entry("empty_outputs", a, e);
      end
`ifdef IDU_PERF_EN
      chk("perf_cnt", perf_cnt, pm[perf_sel]);
`endif
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (bus.out_ready && n != 0) begin
          e = sb.pop_front();
          chk_entry("retire", a, e);
`ifdef IDU_PERF_EN
          pm[e.cls] = pm[e.cls] + 1'b1;
          pm[7] = pm[7] + 1'b1;
`endif
        end
        if (bus.in_valid && n != DEPTH) sb.push_back(ref_decode(bus.in_pc, bus.in_inst));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    bus.in_pc = pc;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.in_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
`ifdef IDU_PERF_EN
    perf_sel = '0;
`endif
    repeat (3) cyc();
    reset = 1'b1;
    cyc();

    // single addi with EXU ready
    bus.out_ready = 1'b1;
    push_one(32'h0050_0093, 32'h0000_1000);
    @(negedge clock);
    chk("addi_valid", 32'(bus.out_valid), 1);
    chk("addi_rd", 32'(bus.out_rd), 1);
    chk("addi_rs1", 32'(bus.out_rs1), 0);
    chk("addi_imm", bus.out_imm, 5);
    chk("addi_alu", 32'(bus.out_alu_op), 0);
    chk("addi_class", 32'(bus.out_class), 0);
    cyc();
    @(negedge clock);
    chk("addi_level_after", 32'(level), 0);
    cyc();

    // fill with EXU stalled, then release in order
    bus.out_ready = 1'b0;
    push_one(32'h0000_A103, 32'h0000_2000);
    push_one(32'h0020_A223, 32'h0000_2004);
    @(negedge clock);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_level", 32'(level), 2);
    cyc();
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("lw_alu", 32'(bus.out_alu_op), 32'b001000);
    chk("lw_imm", bus.out_imm, 0);
    cyc();
    @(negedge clock);
    chk("sw_alu", 32'(bus.out_alu_op), 32'b001001);
    chk("sw_imm", bus.out_imm, 4);
    cyc();

    // full queue, push and pop every cycle
    bus.out_ready = 1'b0;
    push_one(rand_inst(), 32'h0000_3000);
    push_one(rand_inst(), 32'h0000_3004);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst = rand_inst();
      bus.in_pc = 32'h0000_3008 + 32'(4 * i);
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (3) cyc();

    // flush with a concurrent push, both from full and from one entry
    bus.out_ready = 1'b0;
    push_one(32'h0050_0093, 32'h0000_4000);
    push_one(32'h0050_0093, 32'h0000_4004);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("flush_full_level", 32'(level), 0);
    chk("flush_full_valid", 32'(bus.out_valid), 0);
    cyc();
    push_one(32'h0050_0093, 32'h0000_4010);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("flush_one_level", 32'(level), 0);
    cyc();

    // ecall / mret
    push_one(32'h0000_0073, 32'h0000_5000);
    @(negedge clock);
    chk("ecall_flag", 32'(bus.out_is_ecall), 1);
    chk("ecall_rs1", 32'(bus.out_rs1), 17);
    chk("ecall_alu", 32'(bus.out_alu_op), 32'b110010);
    chk("ecall_class", 32'(bus.out_class), 5);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    push_one(32'h3020_0073, 32'h0000_5004);
    @(negedge clock);
    chk("mret_flag", 32'(bus.out_is_mret), 1);
    chk("mret_alu", 32'(bus.out_alu_op), 32'b110011);
    cyc();
    bus.out_ready = 1'b1;
    repeat (2) cyc();

`ifdef IDU_PERF_EN
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    push_one(32'h0050_0093, 32'h0000_6000);
    push_one(32'h0010_0113, 32'h0000_6004);
    push_one(32'h0020_0193, 32'h0000_6008);
    push_one(32'h0000_0463, 32'h0000_600c);
    repeat (3) cyc();
    bus.out_ready = 1'b0;
    push_one(32'h0000_A103, 32'h0000_6010);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    perf_sel = 3'd0;
    #1 chk("perf_compute", perf_cnt, 3);
    perf_sel = 3'd3;
    #1 chk("perf_branch", perf_cnt, 1);
    perf_sel = 3'd1;
    #1 chk("perf_load", perf_cnt, 0);
    perf_sel = 3'd7;
    #1 chk("perf_total", perf_cnt, 4);
    cyc();
    reset = 1'b0;
    for (int s = 0; s < 8; s++) begin
      perf_sel = 3'(s);
      #1 chk("perf_reset", perf_cnt, 0);
    end
    cyc();
    reset = 1'b1;
    cyc();
`endif

    // random traffic with occasional flush and asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_inst = rand_inst();
      bus.in_pc = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush = ($urandom_range(0, 39) == 0);
`ifdef IDU_PERF_EN
      perf_sel = 3'($urandom_range(0, 7));
`endif
      reset = ($urandom_range(0, 499) != 0);
      cyc();
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clock);
    chk("drain_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
